// File: rtl/systolic_mm_sched_if.sv
// ============================================================================
// Module   : systolic_mm_sched_if
// Purpose  : Operand load stream and result stream of the systolic job
//            sequencer, seen from the bus-side adapter (master) and the
//            sequencer (slave).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface systolic_mm_sched_if #(
   parameter int DATA_WIDTH = 32,
   parameter int KW         = 4
);
   logic [KW-1:0]         cfg_k;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      output cfg_k, s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  cfg_k, s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );
endinterface

`default_nettype wire

// File: rtl/systolic_mm_sched.sv
// ============================================================================
// Module   : systolic_mm_sched
// Purpose  : Buffers a 2xK by Kx2 operand set, feeds the 2x2 systolic array
//            with diagonal skew and streams back the four accumulators.
//            Optional completed-job counter: SYSTOLIC_SCHED_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_mm_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int K_MAX      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   systolic_mm_sched_if.slave    bus,
   output logic                  busy,
   output logic                  pe_rst,
   output logic                  func_sel,
   output logic [DATA_WIDTH-1:0] a_row1,
   output logic [DATA_WIDTH-1:0] a_row2,
   output logic [DATA_WIDTH-1:0] b_col1,
   output logic [DATA_WIDTH-1:0] b_col2,
   output logic [DATA_WIDTH-1:0] fir_zero,
   input  logic [DATA_WIDTH-1:0] acc_11,
   input  logic [DATA_WIDTH-1:0] acc_12,
   input  logic [DATA_WIDTH-1:0] acc_21,
   input  logic [DATA_WIDTH-1:0] acc_22,
   output logic [31:0]           job_cnt
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int CW = (KW > 2) ? KW : 2;
   localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CLEAR = 3'd2,
      ST_FEED  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_OUT   = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         k_q, k_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            bank_q, bank_d;
   logic [DATA_WIDTH-1:0] mem_q [4][K_MAX];
   logic [DATA_WIDTH-1:0] mem_d [4][K_MAX];
   logic [DATA_WIDTH-1:0] res_q [4];
   logic [DATA_WIDTH-1:0] res_d [4];

   logic [CW-1:0]         k_cfg, k_eff, cnt_inc, cnt_dec;
   logic                  s_rdy, m_vld, m_lst;
   logic [DATA_WIDTH-1:0] m_dat;

   // K is clamped to 1..K_MAX; it only matters on the first beat of a job
   always_comb begin
      if (bus.cfg_k == '0)
         k_cfg = CW'(1);
      else if (bus.cfg_k > KW'(K_MAX))
         k_cfg = CW'(K_MAX);
      else
         k_cfg = CW'(bus.cfg_k);
   end

   assign k_eff   = (state_q == ST_IDLE) ? k_cfg : k_q;
   assign cnt_inc = cnt_q + CW'(1);
   assign cnt_dec = cnt_q - CW'(1);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      mem_d   = mem_q;
      res_d   = res_q;
      s_rdy   = 1'b0;
      m_vld   = 1'b0;
      m_lst   = 1'b0;
      m_dat   = '0;
      pe_rst  = rst;
      a_row1  = '0;
      a_row2  = '0;
      b_col1  = '0;
      b_col2  = '0;
      case (state_q)
         ST_IDLE, ST_LOAD: begin
            s_rdy = 1'b1;
            if (bus.s_valid) begin
               mem_d[bank_q][cnt_q[AW-1:0]] = bus.s_data;
               k_d     = k_eff;
               state_d = ST_LOAD;
               if (cnt_inc == k_eff) begin
                  cnt_d  = '0;
                  bank_d = bank_q + 2'd1;
                  if (bank_q == 2'd3)
                     state_d = ST_CLEAR;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_CLEAR: begin
            pe_rst  = 1'b1;
            cnt_d   = '0;
            state_d = ST_FEED;
         end
         ST_FEED: begin
            // Row 2 / column 2 lag row 1 / column 1 by one cycle
            if (cnt_q != k_q) begin
               a_row1 = mem_q[0][cnt_q[AW-1:0]];
               b_col1 = mem_q[2][cnt_q[AW-1:0]];
            end
            if (cnt_q != '0) begin
               a_row2 = mem_q[1][cnt_dec[AW-1:0]];
               b_col2 = mem_q[3][cnt_dec[AW-1:0]];
            end
            if (cnt_q == k_q) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CW'(1)) begin
               res_d[0] = acc_11;
               res_d[1] = acc_12;
               res_d[2] = acc_21;
               res_d[3] = acc_22;
               cnt_d    = '0;
               state_d  = ST_OUT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_OUT: begin
            m_vld = 1'b1;
            m_dat = res_q[cnt_q[1:0]];
            m_lst = (cnt_q[1:0] == 2'd3);
            if (bus.m_ready) begin
               if (m_lst) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= CW'(1);
         cnt_q   <= '0;
         bank_q  <= '0;
         res_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         res_q   <= res_d;
      end
      mem_q <= mem_d;
   end

   assign bus.s_ready = s_rdy;
   assign bus.m_valid = m_vld;
   assign bus.m_data  = m_dat;
   assign bus.m_last  = m_lst;
   assign busy        = (state_q != ST_IDLE);
   assign func_sel    = 1'b0;
   assign fir_zero    = '0;

`ifdef SYSTOLIC_SCHED_PERF_EN
   logic        job_done;
   logic [31:0] job_cnt_q, job_cnt_d;

   assign job_done = (state_q == ST_OUT) && bus.m_ready && (cnt_q[1:0] == 2'd3);

   always_comb begin
      job_cnt_d = job_cnt_q;
      if (job_done)
         job_cnt_d = job_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         job_cnt_q <= '0;
      else
         job_cnt_q <= job_cnt_d;
   end

   assign job_cnt = job_cnt_q;
`else
   assign job_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_mm_sched.sv
// ============================================================================
// Module   : tb_systolic_mm_sched
// Purpose  : Self-checking bench for systolic_mm_sched with a behavioural
//            2x2 array and a plain matrix-product reference.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_mm_sched;
   localparam int DW = 32;
   localparam int KM = 8;
   localparam int KW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_mm_sched_if #(.DATA_WIDTH(DW), .KW(KW)) bus ();

   logic          busy, pe_rst, func_sel;
   logic [DW-1:0] a_row1, a_row2, b_col1, b_col2, fir_zero;
   logic [DW-1:0] acc_11, acc_12, acc_21, acc_22;
   logic [31:0]   job_cnt;

   systolic_mm_sched #(.DATA_WIDTH(DW), .K_MAX(KM)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .busy     (busy),
      .pe_rst   (pe_rst),
      .func_sel (func_sel),
      .a_row1   (a_row1),
      .a_row2   (a_row2),
      .b_col1   (b_col1),
      .b_col2   (b_col2),
      .fir_zero (fir_zero),
      .acc_11   (acc_11),
      .acc_12   (acc_12),
      .acc_21   (acc_21),
      .acc_22   (acc_22),
      .job_cnt  (job_cnt)
   );

   // Behavioural 2x2 output-stationary array: rows flow right, columns down
   logic [DW-1:0] a11o, b11o, b12o, a21o;
   always @(posedge clk) begin
      if (pe_rst) begin
         acc_11 <= '0; acc_12 <= '0; acc_21 <= '0; acc_22 <= '0;
         a11o   <= '0; b11o   <= '0; b12o   <= '0; a21o   <= '0;
      end else begin
         acc_11 <= acc_11 + a_row1 * b_col1;
         acc_12 <= acc_12 + a11o * b_col2;
         acc_21 <= acc_21 + a_row2 * b11o;
         acc_22 <= acc_22 + a21o * b12o;
         a11o   <= a_row1;
         b11o   <= b_col1;
         b12o   <= b_col2;
         a21o   <= a_row2;
      end
   end

   int total = 0;
   int bad   = 0;
   int exp_jobs = 0;
   logic [31:0] am [2][KM];
   logic [31:0] bm [KM][2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cref(input int i, input int j, input int k);
      logic [31:0] s = '0;
      for (int e = 0; e < k; e++)
         s = s + am[i][e] * bm[e][j];
      return s;
   endfunction

   function automatic logic [31:0] exp_job_cnt();
`ifdef SYSTOLIC_SCHED_PERF_EN
      return 32'(exp_jobs);
`else
      return 32'd0;
`endif
   endfunction

   task automatic fill_random();
      for (int e = 0; e < KM; e++) begin
         am[0][e] = $urandom; am[1][e] = $urandom;
         bm[e][0] = $urandom; bm[e][1] = $urandom;
      end
   endtask

   // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random; rst_t: FEED step to reset at, -1 none
   task automatic do_job(input int kcfg, input int rmode, input int rst_t);
      int k, j, guard, pc;
      logic r;
      logic [31:0] w, ea1, ea2, eb1, eb2;
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      k = (kcfg == 0) ? 1 : ((kcfg > KM) ? KM : kcfg);
      for (int i = 0; i < 4 * k; i++) begin
         w = (i / k < 2) ? am[i / k][i % k] : bm[i % k][i / k - 2];
         @(negedge clk);
         bus.s_valid = 1'b1;
         bus.s_data  = w;
         bus.cfg_k   = (i == 0) ? kcfg[KW-1:0] : 4'($urandom);
         chk("s_ready_load", bus.s_ready, 1);
      end
      @(negedge clk);
      bus.s_data = $urandom;
      chk("s_ready_after_load", bus.s_ready, 0);
      chk("pe_rst_clear", pe_rst, 1);
      chk("busy_clear", busy, 1);
      chk("a_row1_clear", a_row1, 0);
      bus.s_valid = 1'b0;
      for (int t = 0; t <= k; t++) begin
         @(negedge clk);
         if (t == rst_t) begin
            rst = 1'b1;
            #1;
            chk("pe_rst_during_rst", pe_rst, 1);
            @(negedge clk);
            rst = 1'b0;
            exp_jobs = 0;
            chk("busy_after_rst", busy, 0);
            chk("s_ready_after_rst", bus.s_ready, 1);
            chk("job_cnt_after_rst", job_cnt, exp_job_cnt());
            for (int c = 0; c < 12; c++) begin
               @(negedge clk);
               chk("no_m_valid_after_rst", bus.m_valid, 0);
            end
            return;
         end
         ea1 = (t < k)  ? am[0][t]     : 32'd0;
         ea2 = (t >= 1) ? am[1][t - 1] : 32'd0;
         eb1 = (t < k)  ? bm[t][0]     : 32'd0;
         eb2 = (t >= 1) ? bm[t - 1][1] : 32'd0;
         chk("feed_a_row1", a_row1, ea1);
         chk("feed_a_row2", a_row2, ea2);
         chk("feed_b_col1", b_col1, eb1);
         chk("feed_b_col2", b_col2, eb2);
         chk("feed_pe_rst", pe_rst, 0);
         chk("feed_m_valid", bus.m_valid, 0);
      end
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         chk("drain_m_valid", bus.m_valid, 0);
         chk("drain_a_row2", a_row2, 0);
         chk("drain_b_col2", b_col2, 0);
      end
      j = 0; guard = 0; pc = 0;
      while (j < 4) begin
         @(negedge clk);
         r = (rmode == 0) ? 1'b1 : ((rmode == 1) ? pat[pc % 4] : 1'($urandom));
         pc++;
         bus.m_ready = r;
         chk("out_m_valid", bus.m_valid, 1);
         chk("out_m_data", bus.m_data, cref(j / 2, j % 2, k));
         chk("out_m_last", bus.m_last, (j == 3));
         chk("out_s_ready", bus.s_ready, 0);
         if (r) j++;
         guard++;
         if (guard > 200) begin
            chk("out_timeout", 32'(j), 4);
            j = 4;
         end
      end
      @(negedge clk);
      bus.m_ready = 1'b0;
      exp_jobs++;
      chk("idle_busy", busy, 0);
      chk("idle_s_ready", bus.s_ready, 1);
      chk("idle_m_valid", bus.m_valid, 0);
      chk("idle_job_cnt", job_cnt, exp_job_cnt());
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.cfg_k   = '0;
      bus.m_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_last", bus.m_last, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pe_rst", pe_rst, 1);
      chk("rst_a_row1", a_row1, 0);
      chk("rst_b_col2", b_col2, 0);
      chk("rst_job_cnt", job_cnt, 0);
      chk("func_sel", func_sel, 0);
      chk("fir_zero", fir_zero, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("pe_rst_released", pe_rst, 0);

      // K=2 worked example: 19, 22, 43, 50
      am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
      bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
      chk("ref_c11", cref(0, 0, 2), 19);
      chk("ref_c22", cref(1, 1, 2), 50);
      do_job(2, 0, -1);

      // K=8 all ones, B column 1 = 2: 8, 16, 8, 16
      for (int e = 0; e < KM; e++) begin
         am[0][e] = 1; am[1][e] = 1; bm[e][0] = 1; bm[e][1] = 2;
      end
      do_job(8, 0, -1);

      fill_random(); do_job(0, 0, -1);
      fill_random(); do_job(15, 2, -1);
      fill_random(); do_job(3, 1, -1);

      // Reset in third FEED cycle, then a clean K=2 job
      fill_random(); do_job(2, 0, 2);
      am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
      bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
      do_job(2, 1, -1);

      for (int n = 0; n < 6; n++) begin
         fill_random();
         do_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire

// File: doc/systolic_mm_sched.md
# systolic_mm_sched

Job sequencer for the 2x2 systolic multiply array. It accepts the operands of one 2xK by Kx2 product as a valid/ready word stream and buffers them. It then clears the PE accumulators and drives the row/column inputs with the diagonal skew the array needs. After drain it captures the four accumulators and returns them as a 4-word result stream. It sits between the bus-side stream adapter and the array, and always runs the array in matrix mode.

## Interface
- DATA_WIDTH, 32, operand and result word width
- K_MAX, 8, maximum inner dimension; KW = $clog2(K_MAX+1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cfg_k  in  KW  inner dimension K, sampled with the first accepted load beat
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat accepted when s_valid&s_ready
- s_data  in  DATA_WIDTH  operand word
- m_valid  out  1  result beat valid
- m_ready  in  1  result sink ready
- m_data  out  DATA_WIDTH  result word
- m_last  out  1  high on 4th result beat
- busy  out  1  state != IDLE
- pe_rst  out  1  array reset / accumulator clear
- func_sel  out  1  constant 0 (matrix mode)
- a_row1, a_row2  out  DATA_WIDTH  to array i_data_11, i_data_21
- b_col1, b_col2  out  DATA_WIDTH  to array i_tap_11, i_tap_12
- fir_zero  out  DATA_WIDTH  constant 0; drives all four i_fir_* inputs
- acc_11, acc_12, acc_21, acc_22  in  DATA_WIDTH  array o_data_*
- job_cnt  out  32  completed-job count (see Configuration)

## Operation
- FSM states: IDLE, LOAD, CLEAR, FEED, DRAIN, OUT.
- IDLE: s_ready=1. The first accepted beat latches K = clamp(cfg_k, 1, K_MAX), stores the word and moves to LOAD.
- LOAD: s_ready=1 until 4K beats total are accepted, then s_ready drops and the FSM moves to CLEAR. Beat order:
  - A row 0, elements 0..K-1
  - A row 1, elements 0..K-1
  - B column 0, elements 0..K-1
  - B column 1, elements 0..K-1
- Buffers are 4 banks of K_MAX words each.
- CLEAR: one cycle with pe_rst=1. All array inputs are 0.
- FEED: K+1 cycles, t = 0..K.
  - a_row1 = A[0][t] for t<K, else 0.
  - a_row2 = A[1][t-1] for 1<=t<=K, else 0.
  - b_col1 = B[t][0] for t<K, else 0.
  - b_col2 = B[t-1][1] for 1<=t<=K, else 0.
- DRAIN: fixed 2 cycles with all inputs 0. On the last DRAIN cycle acc_11..acc_22 are snapshotted into result registers.
- OUT: m_valid=1 and the beats go out in order c11, c12, c21, c22. m_last is high on c22. A beat advances only on m_valid&m_ready. After the c22 handshake the FSM returns to IDLE and job_cnt increments.
- Whenever not FEED, a_row*/b_col* are 0, so accumulators hold.
- pe_rst = rst | (state==CLEAR).
- Arithmetic: no width growth. Results are the array's DATA_WIDTH accumulators, passed through unmodified.

## Timing
- Reset values:
  - FSM in IDLE
  - s_ready=1, m_valid=0, m_last=0, m_data=0, busy=0
  - a_row*/b_col*=0, pe_rst=1 while rst is high, job_cnt=0
- Reset mid-job: the next cycle is IDLE. Partial operands and pending results are discarded, and no m_valid follows.
- Latency: last load beat handshake → m_valid high is 1 (CLEAR) + K+1 (FEED) + 2 (DRAIN) + 1 = K+5 cycles.
- Back-pressure:
  - m_ready low holds m_data and m_last stable.
  - s_ready stays 0 from CLEAR through OUT, so no new load overlaps a job.
- cfg_k is ignored after the first beat. Changing it mid-load has no effect.
- In IDLE, the cycle after c22 is accepted, s_ready=1 again.

## Configuration
- SYSTOLIC_SCHED_PERF_EN:
  - Defined: job_cnt is a 32-bit counter, +1 per completed job (c22 handshake). It wraps 0xFFFFFFFF→0 and is cleared by rst.
  - Undefined: job_cnt is constant 0 and no counter logic is built.

## Test plan
- K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] (B rows) → results 19, 22, 43, 50. m_last only on 50. m_valid rises 7 cycles after the 8th load beat.
- K=8, A and B all 1 except B column 1 = 2 → results 8, 16, 8, 16. FEED lasts 9 cycles and skew is checked per cycle on a_row2/b_col2.
- cfg_k=0 and then cfg_k=15 with K_MAX=8 → K clamps to 1 and then 8. Exactly 4 and 32 beats are accepted, and s_ready drops afterwards.
- m_ready toggled 1,0,0,1,... during OUT → every beat is held stable while stalled. Order c11, c12, c21, c22 is kept. The next job's s_ready rises only after c22.
- rst asserted in cycle 3 of FEED → pe_rst=1 and the FSM is in IDLE next cycle with no m_valid. A following clean K=2 job gives correct results.
- With SYSTOLIC_SCHED_PERF_EN, 3 back-to-back jobs → job_cnt=3. Without the macro, job_cnt stays 0.
